// File: rtl/uart_cmd_host.sv
// uart_cmd_host: frames host commands into the controller byte protocol and collects the response.
// Optional response timeout is compiled in with CMD_HOST_TIMEOUT_EN.
module uart_cmd_host #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_OP,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [WIDTH-1:0]      CMD_DATA,
  input  logic [WIDTH-1:0]      CMD_OPB,
  input  logic [3:0]            CMD_FUN,
  output logic [WIDTH-1:0]      TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  input  logic [WIDTH-1:0]      RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RSP_VALID,
  output logic [2*WIDTH-1:0]    RSP_DATA,
  output logic                  RSP_ERR,
  output logic                  BUSY
);
  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_ALUN = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
  state_t state, state_next;

  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      a_q, b_q;
  logic [3:0]            fun_q;
  logic [1:0]            byte_cnt, rx_cnt, last_idx;
  logic [WIDTH-1:0]      tx_data_q;
  logic                  tx_valid_q;
  logic [2*WIDTH-1:0]    rx_buf, rx_buf_next, rsp_data_q;
  logic                  accept, tx_fire, tx_last, rx_take, rx_last, tmo_hit, enter_done;

  function automatic logic [WIDTH-1:0] frame_byte(
    input logic [1:0]            op,
    input logic [1:0]            idx,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [WIDTH-1:0]      a,
    input logic [WIDTH-1:0]      b,
    input logic [3:0]            fun
  );
    logic [WIDTH-1:0] f;
    f = '0;
    case (op)
      OP_WR: begin
        case (idx)
          2'd0:    f = WIDTH'(8'hAA);
          2'd1:    f = WIDTH'(addr);
          default: f = a;
        endcase
      end
      OP_RD:   f = (idx == 2'd0) ? WIDTH'(8'hBB) : WIDTH'(addr);
      OP_ALU: begin
        case (idx)
          2'd0:    f = WIDTH'(8'hCC);
          2'd1:    f = a;
          2'd2:    f = b;
          default: f = WIDTH'(fun);
        endcase
      end
      default: f = (idx == 2'd0) ? WIDTH'(8'hDD) : WIDTH'(fun);
    endcase
    return f;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    last_idx    = 2'd1;
    rx_buf_next = rx_buf;
    case (op_q)
      OP_WR:   last_idx = 2'd2;
      OP_ALU:  last_idx = 2'd3;
      default: last_idx = 2'd1;
    endcase
    accept     = CMD_VALID && CMD_READY;
    tx_fire    = (state == SEND) && tx_valid_q && TX_READY;
    tx_last    = tx_fire && (byte_cnt == last_idx);
    rx_take    = (state == WAIT_RSP) && RX_VALID;
    rx_last    = rx_take && ((op_q == OP_RD) || (rx_cnt == 2'd1));
    if (rx_take) begin
      if (rx_cnt == 2'd0) rx_buf_next[WIDTH-1:0]       = RX_DATA;
      else                rx_buf_next[2*WIDTH-1:WIDTH] = RX_DATA;
    end
    case (state)
      IDLE:     if (accept) state_next = SEND;
      SEND:     if (tx_last) state_next = (op_q == OP_WR) ? DONE : WAIT_RSP;
      WAIT_RSP: if (rx_last || tmo_hit) state_next = DONE;
      default:  state_next = IDLE;
    endcase
    enter_done = (state_next == DONE) && (state != DONE);
  end

  // The next frame byte is loaded on the transfer edge so TX_VALID never drops mid-frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q       <= OP_WR;
      addr_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      byte_cnt   <= '0;
      rx_cnt     <= '0;
      rx_buf     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        op_q       <= CMD_OP;
        addr_q     <= CMD_ADDR;
        a_q        <= CMD_DATA;
        b_q        <= CMD_OPB;
        fun_q      <= CMD_FUN;
        byte_cnt   <= '0;
        rx_cnt     <= '0;
        rx_buf     <= '0;
        tx_data_q  <= frame_byte(CMD_OP, 2'd0, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN);
        tx_valid_q <= 1'b1;
      end
      if (tx_fire) begin
        if (tx_last) begin
          tx_valid_q <= 1'b0;
        end else begin
          byte_cnt  <= byte_cnt + 2'd1;
          tx_data_q <= frame_byte(op_q, byte_cnt + 2'd1, addr_q, a_q, b_q, fun_q);
        end
      end
      if (rx_take) begin
        rx_cnt <= rx_cnt + 2'd1;
        rx_buf <= rx_buf_next;
      end
      if (enter_done) rsp_data_q <= rx_buf_next;
    end
  end

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

`ifdef CMD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          rsp_err_q;

  // An RX byte in the expiry cycle takes priority over the timeout.
  assign tmo_hit = (state == WAIT_RSP) && !rx_take && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST || (state != WAIT_RSP) || rx_take) tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + TW'(1);
    if (RST)             rsp_err_q <= 1'b0;
    else if (enter_done) rsp_err_q <= tmo_hit;
  end

  assign RSP_ERR = rsp_err_q;
`else
  assign tmo_hit = 1'b0;
  assign RSP_ERR = 1'b0;
`endif

  assign CMD_READY = (state == IDLE) && !RST;
  assign BUSY      = (state != IDLE);
  assign RSP_VALID = (state == DONE);
  assign RSP_DATA  = rsp_data_q;
  assign TX_DATA   = tx_data_q;
  assign TX_VALID  = tx_valid_q;
endmodule
